// File: rtl/cla_nibble_serial_adder_if.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_adder_if
//   Bundles the start/done handshake, the operands and the result of the
//   nibble-serial adder.
//   master : drives start, A, B, Cin; observes busy, done, Sum, Cout, Ovf
//   slave  : the adder itself (opposite directions)
// ---------------------------------------------------------------------------
interface cla_nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_adder
//   Multi-cycle WIDTH-bit adder computing A + B + Cin through a single 4-bit
//   carry-lookahead slice, one nibble per clock, LSB nibble first. The slice
//   carry is registered between nibbles. Sum/Cout/Ovf are updated only when
//   the last nibble completes and hold until the next completion or reset.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : synchronous active-low reset
//     bus    : slave side of cla_nibble_serial_adder_if
//              start/A/B/Cin in, busy/done/Sum/Cout/Ovf out
// ---------------------------------------------------------------------------
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cla_nibble_serial_adder_if.slave    bus
);

    localparam int NSL   = WIDTH / 4;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 4-bit lookahead slice; returns {c4, c3, s[3:0]}.
    // c3 is the carry into bit 3 and feeds the overflow detection.
    function automatic logic [5:0] cla_slice(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       cin
    );
        logic [3:0] p;
        logic [3:0] g;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        p  = a ^ b;
        g  = a & b;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c4, c3, p ^ {c3, c2, c1, cin}};
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               accept_s;
    logic               run_s;
    logic               last_s;
    logic [IDX_W+1:0]   bit_off_s;
    logic [5:0]         slice_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_RUN;
                else           state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) state_d = ST_DONE;
                else                   state_d = ST_RUN;
            end
            ST_DONE: begin
                // A start in DONE is accepted immediately for back-to-back ops
                if (bus.start) state_d = ST_RUN;
                else           state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        accept_s = 1'b0;
        run_s    = 1'b0;
        last_s   = 1'b0;
        case (state_q)
            ST_IDLE: accept_s = bus.start;
            ST_RUN: begin
                run_s  = 1'b1;
                last_s = (idx_q == LAST_IDX);
            end
            ST_DONE: accept_s = bus.start;
            default: begin
                accept_s = 1'b0;
                run_s    = 1'b0;
                last_s   = 1'b0;
            end
        endcase
    end

    // Shared CLA slice on the current nibble; accumulator with that nibble merged
    always_comb begin
        bit_off_s = {idx_q, 2'b00};
        slice_s   = cla_slice(a_q[bit_off_s +: 4], b_q[bit_off_s +: 4], carry_q);
        acc_d     = acc_q;
        acc_d[bit_off_s +: 4] = slice_s[3:0];
    end

    // Operand capture, per-nibble accumulation and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            idx_q   <= {IDX_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            busy_q <= (state_d == ST_RUN);
            done_q <= (state_d == ST_DONE);
            if (accept_s) begin
                a_q     <= bus.A;
                b_q     <= bus.B;
                carry_q <= bus.Cin;
                idx_q   <= {IDX_W{1'b0}};
            end else if (run_s) begin
                acc_q   <= acc_d;
                carry_q <= slice_s[5];
                idx_q   <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (last_s) begin
                    // acc_d already holds the final nibble
                    sum_q  <= acc_d;
                    cout_q <= slice_s[5];
                    ovf_q  <= slice_s[4] ^ slice_s[5];
                end else begin
                    sum_q  <= sum_q;
                    cout_q <= cout_q;
                    ovf_q  <= ovf_q;
                end
            end else begin
                carry_q <= carry_q;
                idx_q   <= idx_q;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;

endmodule
